channel_llr_init: RTL

Streaming channel-LLR initialiser for the LDPC decoder front end: maps received key bits xi to signed fixed-point initial LLRs L(Pi) = ±ln((1−q)/q) for a per-frame QBER setting. It generalises the single combinational QBER lookup into a multi-lane, valid/ready pipelined block with a runtime-writable magnitude table, per-frame rounding attenuation, and frame tracking. It sits between the sifted-key input FIFO and the variable-node memory loader.

---
 rtl/channel_llr_init_pkg.sv | 29 ++
 rtl/channel_llr_init_if.sv | 30 +++
 rtl/channel_llr_init_lane_map.sv | 27 ++
 rtl/channel_llr_init.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/channel_llr_init_pkg.sv
// rtl/channel_llr_init_pkg.sv - shared constants and types for the channel LLR initialiser
// Default magnitudes are ln((1-q)/q) in Q5.10 for QBER q = 0.01 .. 0.11.
package llr_init_pkg;

  localparam int NUM_QBER = 11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } llr_state_t;

  function automatic logic [15:0] def_mag(input int idx);
    case (idx)
      0:       def_mag = 16'h1261;
      1:       def_mag = 16'h0F91;
      2:       def_mag = 16'h0DE8;
      3:       def_mag = 16'h0CB6;
      4:       def_mag = 16'h0BC7;
      5:       def_mag = 16'h0B02;
      6:       def_mag = 16'h0A59;
      7:       def_mag = 16'h09C5;
      8:       def_mag = 16'h0941;
      9:       def_mag = 16'h08CA;
      10:      def_mag = 16'h085D;
      default: def_mag = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/channel_llr_init_if.sv
// rtl/channel_llr_init_if.sv - input beat stream and output LLR stream of the initialiser
interface channel_llr_init_if #(
  parameter int LANES   = 4,
  parameter int LLR_W   = 15,
  parameter int QSEL_W  = 4,
  parameter int SCALE_W = 2
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES-1:0]       in_bits;
  logic                   in_last;
  logic [QSEL_W-1:0]      qber_sel;
  logic [SCALE_W-1:0]     scale;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*LLR_W-1:0] out_llr;
  logic                   out_last;

  modport master (
    output in_valid, in_bits, in_last, qber_sel, scale, out_ready,
    input  in_ready, out_valid, out_llr, out_last
  );

  modport slave (
    input  in_valid, in_bits, in_last, qber_sel, scale, out_ready,
    output in_ready, out_valid, out_llr, out_last
  );

endinterface

// File: rtl/channel_llr_init_lane_map.sv
// rtl/channel_llr_init_lane_map.sv - one lane: magnitude, rounding shift, sign from xi
// Rounding is half-up; the extra MSB of w_ext absorbs the rounding carry.
module llr_lane_map #(
  parameter int LLR_W   = 15,
  parameter int SCALE_W = 2
) (
  input  logic [LLR_W-2:0]   i_mag,
  input  logic [SCALE_W-1:0] i_scale,
  input  logic               i_xi,
  output logic [LLR_W-1:0]   o_llr
);

  logic [LLR_W-1:0] w_ext;
  logic [LLR_W-1:0] w_bias;
  logic [LLR_W-1:0] w_rnd;

  always_comb begin
    w_ext  = {1'b0, i_mag};
    w_bias = '0;
    if (i_scale != '0) begin
      w_bias = LLR_W'(1) << (i_scale - SCALE_W'(1));
    end
    w_rnd = (w_ext + w_bias) >> i_scale;
    o_llr = i_xi ? (-w_rnd) : w_rnd;
  end

endmodule

// File: rtl/channel_llr_init.sv
// rtl/channel_llr_init.sv - streaming channel-LLR initialiser, two-stage stall pipeline
// S1 registers table read, bits and last; S2 registers the signed per-lane LLRs.
module channel_llr_init
  import llr_init_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int LLR_W   = 15,
  parameter int QSEL_W  = 4,
  parameter int SCALE_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  channel_llr_init_if.slave   bus,
  input  logic                i_cfg_we,
  input  logic [QSEL_W-1:0]   i_cfg_addr,
  input  logic [LLR_W-2:0]    i_cfg_data,
  output logic                o_cfg_ready,
  output logic                o_err_qsel,
  output logic [15:0]         o_frame_beats
);

  localparam int DEPTH = 2**QSEL_W;

  llr_state_t             r_state;
  llr_state_t             w_state_nxt;
  logic [LLR_W-2:0]       r_table [DEPTH];
  logic [QSEL_W-1:0]      r_frame_qsel;
  logic [SCALE_W-1:0]     r_frame_scale;
  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic [LANES-1:0]       r_s1_bits;
  logic [LLR_W-2:0]       r_s1_mag;
  logic [SCALE_W-1:0]     r_s1_scale;
  logic                   r_s2_valid;
  logic                   r_s2_last;
  logic [LANES*LLR_W-1:0] r_s2_llr;
  logic [15:0]            r_cnt;
  logic [15:0]            r_frame_beats;
  logic                   r_err;

  logic                   w_en;
  logic                   w_acc;
  logic                   w_first;
  logic                   w_cfg_ready;
  logic [QSEL_W-1:0]      w_qsel;
  logic [SCALE_W-1:0]     w_scale;
  logic [LANES*LLR_W-1:0] w_lane_llr;

  assign w_en        = bus.out_ready || !r_s2_valid;
  assign bus.in_ready = w_en && rst_n;
  assign w_acc       = bus.in_valid && bus.in_ready;
  assign w_first     = w_acc && (r_state == ST_IDLE);
  // The first beat of a frame is processed with its own qber_sel/scale, not the stale frame registers.
  assign w_qsel      = (r_state == ST_IDLE) ? bus.qber_sel : r_frame_qsel;
  assign w_scale     = (r_state == ST_IDLE) ? bus.scale    : r_frame_scale;
  assign w_cfg_ready = (r_state == ST_IDLE) && !r_s1_valid && !r_s2_valid && !bus.in_valid;

  assign bus.out_valid = r_s2_valid;
  assign bus.out_last  = r_s2_last;
  assign bus.out_llr   = r_s2_llr;
  assign o_cfg_ready   = w_cfg_ready;
  assign o_err_qsel    = r_err;
  assign o_frame_beats = r_frame_beats;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_acc && !bus.in_last) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_acc && bus.in_last)  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= (LLR_W-1)'(def_mag(i));
      end
    end else if (i_cfg_we && w_cfg_ready) begin
      r_table[i_cfg_addr] <= i_cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_qsel  <= '0;
      r_frame_scale <= '0;
      r_err         <= 1'b0;
    end else if (w_first) begin
      r_frame_qsel  <= bus.qber_sel;
      r_frame_scale <= bus.scale;
      if (int'(bus.qber_sel) >= NUM_QBER && r_table[bus.qber_sel] == '0) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_frame_beats <= '0;
    end else if (w_acc) begin
      if (bus.in_last) begin
        r_frame_beats <= (r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'd1;
        r_cnt         <= '0;
      end else if (r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    llr_lane_map #(
      .LLR_W   (LLR_W),
      .SCALE_W (SCALE_W)
    ) u_lane (
      .i_mag   (r_s1_mag),
      .i_scale (r_s1_scale),
      .i_xi    (r_s1_bits[g]),
      .o_llr   (w_lane_llr[g*LLR_W +: LLR_W])
    );
  end

  // One shared enable: the whole pipeline freezes while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_bits  <= '0;
      r_s1_mag   <= '0;
      r_s1_scale <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_llr   <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_acc;
      r_s1_last  <= bus.in_last;
      r_s1_bits  <= bus.in_bits;
      r_s1_mag   <= r_table[w_qsel];
      r_s1_scale <= w_scale;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid && r_s1_last;
      r_s2_llr   <= w_lane_llr;
    end
  end

endmodule
